// File: rtl/mips_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready memory port, holds one
// instruction for decode and computes the next PC from the decoder's control_type on retire.
module mips_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clock,
    input  logic             reset,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic             inst_valid,
    output logic [31:0]      inst,
    output logic [5:0]       opcode,
    output logic [5:0]       funct,
    output logic [31:0]      pc,
    output logic [31:0]      pc4,
    input  logic             inst_ack,
    input  logic [1:0]       control_type,
    input  logic [31:0]      branch_offset,
    input  logic [31:0]      jr_target,
    input  logic             except,
    output logic             halted,
    output logic             fetch_fault,
    output logic [CNT_W-1:0] inst_count
);

    typedef enum logic [1:0] {S_FETCH, S_HOLD, S_HALT} state_t;

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       inst_q, inst_d;
    logic              valid_q, valid_d;
    logic              halted_q, halted_d;
    logic              fault_q, fault_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [31:0]       pc4_w;
    logic [31:0]       next_pc;

    assign pc4_w = pc_q + 32'd4;

    always_comb begin
        next_pc = pc4_w;
        case (control_type)
            2'b00:   next_pc = pc4_w;
            2'b01:   next_pc = pc4_w + (branch_offset << 2);
            2'b10:   next_pc = {pc4_w[31:28], inst_q[25:0], 2'b00};
            default: next_pc = jr_target;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            inst_q   <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        fault_d  = fault_q;
        count_d  = count_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    inst_d  = imem_rdata;
                    valid_d = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                // Retire: an illegal instruction wins over any target check, and a bad
                // target halts with pc still pointing at the offending instruction.
                if (inst_ack && valid_q) begin
                    if (except) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end else if (next_pc[1:0] != 2'b00) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                        fault_d  = 1'b1;
                    end else begin
                        pc_d    = next_pc;
                        valid_d = 1'b0;
                        count_d = count_q + CNT_W'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    assign imem_req    = (state_q == S_FETCH);
    assign imem_addr   = pc_q;
    assign inst_valid  = valid_q;
    assign inst        = inst_q;
    assign opcode      = inst_q[31:26];
    assign funct       = inst_q[5:0];
    assign pc          = pc_q;
    assign pc4         = pc4_w;
    assign halted      = halted_q;
    assign fetch_fault = fault_q;
    assign inst_count  = count_q;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit: one task per scenario, expected values hand-computed.
module tb_mips_fetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        inst_ack = 1'b0;
    logic [1:0]  control_type = 2'b00;
    logic [31:0] branch_offset = '0;
    logic [31:0] jr_target = '0;
    logic        except = 1'b0;
    logic        halted;
    logic        fetch_fault;
    logic [31:0] inst_count;

    int tests_run = 0;
    int tests_failed = 0;

    mips_fetch_unit #(.RESET_PC(32'h0040_0000), .CNT_W(32)) dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .opcode(opcode), .funct(funct),
        .pc(pc), .pc4(pc4), .inst_ack(inst_ack), .control_type(control_type),
        .branch_offset(branch_offset), .jr_target(jr_target), .except(except),
        .halted(halted), .fetch_fault(fetch_fault), .inst_count(inst_count)
    );

    always #5 clock = ~clock;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; imem_ready = 1'b0; inst_ack = 1'b0; except = 1'b0;
        control_type = 2'b00;
        cyc(1);
        reset = 1'b0;
    endtask

    // Fetch one word (ready on the first FETCH cycle), then ack it with the given control.
    task automatic fetch_retire(input logic [31:0] word, input logic [1:0] ctl,
                                input logic [31:0] off, input logic [31:0] jr,
                                input logic exc);
        imem_ready = 1'b1; imem_rdata = word;
        cyc(1);
        imem_ready = 1'b0;
        inst_ack = 1'b1; control_type = ctl; branch_offset = off; jr_target = jr; except = exc;
        cyc(1);
        inst_ack = 1'b0; except = 1'b0; control_type = 2'b00;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++; if (imem_req !== 1'b1) begin tests_failed++; $display("FAIL reset_req: got %b exp 1", imem_req); end
        tests_run++; if (pc !== 32'h0040_0000) begin tests_failed++; $display("FAIL reset_pc: got %h exp 00400000", pc); end
        tests_run++; if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b exp 0", inst_valid); end
        tests_run++; if (inst !== 32'h0) begin tests_failed++; $display("FAIL reset_inst: got %h exp 0", inst); end
        tests_run++; if ({halted, fetch_fault} !== 2'b00) begin tests_failed++; $display("FAIL reset_halt: got %b exp 00", {halted, fetch_fault}); end
        tests_run++; if (inst_count !== 32'd0) begin tests_failed++; $display("FAIL reset_count: got %0d exp 0", inst_count); end
    endtask

    task automatic test_seq();
        do_reset();
        imem_ready = 1'b1; imem_rdata = 32'h2008_0005;
        cyc(1);
        imem_ready = 1'b0;
        tests_run++; if (inst_valid !== 1'b1) begin tests_failed++; $display("FAIL seq_valid: got %b exp 1", inst_valid); end
        tests_run++; if (opcode !== 6'h08) begin tests_failed++; $display("FAIL seq_opcode: got %h exp 08", opcode); end
        tests_run++; if (funct !== 6'h05) begin tests_failed++; $display("FAIL seq_funct: got %h exp 05", funct); end
        tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL seq_req_hold: got %b exp 0", imem_req); end
        tests_run++; if (pc4 !== 32'h0040_0004) begin tests_failed++; $display("FAIL seq_pc4: got %h exp 00400004", pc4); end
        inst_ack = 1'b1; control_type = 2'b00;
        cyc(1);
        inst_ack = 1'b0;
        tests_run++; if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL seq_valid_drop: got %b exp 0", inst_valid); end
        tests_run++; if (pc !== 32'h0040_0004) begin tests_failed++; $display("FAIL seq_pc: got %h exp 00400004", pc); end
        tests_run++; if (inst_count !== 32'd1) begin tests_failed++; $display("FAIL seq_count: got %0d exp 1", inst_count); end
        tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0004) begin tests_failed++; $display("FAIL seq_req_again: got %b/%h exp 1/00400004", imem_req, imem_addr); end
    endtask

    task automatic test_stall();
        do_reset();
        imem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0000 || inst_valid !== 1'b0) begin
                tests_failed++; $display("FAIL stall_req[%0d]: got req=%b addr=%h valid=%b exp 1/00400000/0", i, imem_req, imem_addr, inst_valid);
            end
        end
        imem_ready = 1'b1; imem_rdata = 32'h1111_2222;
        cyc(1);
        imem_rdata = 32'h3333_4444;
        cyc(3);
        imem_ready = 1'b0;
        tests_run++; if (inst !== 32'h1111_2222 || imem_req !== 1'b0 || inst_valid !== 1'b1) begin
            tests_failed++; $display("FAIL stall_hold_ignore: got inst=%h req=%b valid=%b exp 11112222/0/1", inst, imem_req, inst_valid);
        end
        except = 1'b1;
        cyc(2);
        except = 1'b0;
        tests_run++; if (halted !== 1'b0 || inst_valid !== 1'b1) begin tests_failed++; $display("FAIL stall_unacked_except: got halted=%b valid=%b exp 0/1", halted, inst_valid); end
    endtask

    task automatic test_branch_jump();
        do_reset();
        for (int i = 0; i < 4; i++) fetch_retire(32'h0, 2'b00, 32'h0, 32'h0, 1'b0);
        tests_run++; if (pc !== 32'h0040_0010 || inst_count !== 32'd4) begin tests_failed++; $display("FAIL br_setup: got pc=%h cnt=%0d exp 00400010/4", pc, inst_count); end
        fetch_retire(32'h1000_FFFE, 2'b01, 32'hFFFF_FFFE, 32'h0, 1'b0);
        tests_run++; if (pc !== 32'h0040_000C || inst_count !== 32'd5) begin tests_failed++; $display("FAIL br_back: got pc=%h cnt=%0d exp 0040000C/5", pc, inst_count); end
        do_reset();
        fetch_retire(32'h0810_0008, 2'b10, 32'h0, 32'h0, 1'b0);
        tests_run++; if (pc !== 32'h0040_0020) begin tests_failed++; $display("FAIL j_target: got %h exp 00400020", pc); end
        fetch_retire(32'h0320_0008, 2'b11, 32'h0, 32'h0040_0100, 1'b0);
        tests_run++; if (pc !== 32'h0040_0100 || inst_count !== 32'd2) begin tests_failed++; $display("FAIL jr_target: got pc=%h cnt=%0d exp 00400100/2", pc, inst_count); end
        fetch_retire(32'h0320_0008, 2'b11, 32'h0, 32'hFFFF_FFFC, 1'b0);
        fetch_retire(32'h0, 2'b00, 32'h0, 32'h0, 1'b0);
        tests_run++; if (pc !== 32'h0000_0000 || halted !== 1'b0) begin tests_failed++; $display("FAIL pc_wrap: got pc=%h halted=%b exp 00000000/0", pc, halted); end
    endtask

    task automatic test_except_halt();
        do_reset();
        fetch_retire(32'hFC00_0000, 2'b00, 32'h0, 32'h0, 1'b1);
        tests_run++; if (halted !== 1'b1 || fetch_fault !== 1'b0) begin tests_failed++; $display("FAIL exc_halted: got %b/%b exp 1/0", halted, fetch_fault); end
        tests_run++; if (pc !== 32'h0040_0000 || inst_count !== 32'd0) begin tests_failed++; $display("FAIL exc_pc_cnt: got %h/%0d exp 00400000/0", pc, inst_count); end
        inst_ack = 1'b1; imem_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            tests_run++; if (imem_req !== 1'b0 || halted !== 1'b1 || inst_valid !== 1'b1 || inst !== 32'hFC00_0000) begin
                tests_failed++; $display("FAIL exc_stuck[%0d]: got req=%b halted=%b valid=%b inst=%h exp 0/1/1/fc000000", i, imem_req, halted, inst_valid, inst);
            end
        end
        inst_ack = 1'b0; imem_ready = 1'b0;
        do_reset();
        tests_run++; if (pc !== 32'h0040_0000 || halted !== 1'b0 || imem_req !== 1'b1 || inst_valid !== 1'b0) begin
            tests_failed++; $display("FAIL exc_reset_exit: got pc=%h halted=%b req=%b valid=%b exp 00400000/0/1/0", pc, halted, imem_req, inst_valid);
        end
    endtask

    task automatic test_fault();
        do_reset();
        fetch_retire(32'h0320_0008, 2'b11, 32'h0, 32'h0040_0102, 1'b0);
        tests_run++; if (fetch_fault !== 1'b1 || halted !== 1'b1 || imem_req !== 1'b0) begin tests_failed++; $display("FAIL fault_flags: got f=%b h=%b req=%b exp 1/1/0", fetch_fault, halted, imem_req); end
        tests_run++; if (pc !== 32'h0040_0000 || inst_count !== 32'd0) begin tests_failed++; $display("FAIL fault_pc_cnt: got %h/%0d exp 00400000/0", pc, inst_count); end
        do_reset();
        fetch_retire(32'h0320_0008, 2'b11, 32'h0, 32'h0040_0102, 1'b1);
        tests_run++; if (halted !== 1'b1 || fetch_fault !== 1'b0 || pc !== 32'h0040_0000) begin tests_failed++; $display("FAIL fault_exc_prio: got h=%b f=%b pc=%h exp 1/0/00400000", halted, fetch_fault, pc); end
    endtask

    task automatic test_reset_mid_fetch();
        do_reset();
        fetch_retire(32'h0, 2'b00, 32'h0, 32'h0, 1'b0);
        reset = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        cyc(1);
        reset = 1'b0; imem_ready = 1'b0;
        tests_run++; if (inst_valid !== 1'b0 || pc !== 32'h0040_0000 || inst_count !== 32'd0 || inst !== 32'h0) begin
            tests_failed++; $display("FAIL reset_mid: got valid=%b pc=%h cnt=%0d inst=%h exp 0/00400000/0/0", inst_valid, pc, inst_count, inst);
        end
    endtask

    initial begin
        test_reset();
        test_seq();
        test_stall();
        test_branch_jump();
        test_except_halt();
        test_fault();
        test_reset_mid_fetch();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
